io_mem_responder: RTL and testbench

IO_MEM_RESPONDER -- requirements
Module: io_mem_responder

---
 rtl/io_mem_responder.sv | 219 +++++++++++++++++++++
 tb/tb_io_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mem_responder.sv
// ---------------------------------------------------------------------------
// io_mem_responder
//
// Memory-mapped I/O slave for a simple in-order core. It decodes the
// execute-stage address and serves a small register page:
//
//   offset 0x00  status   (R)  bit0 TX FIFO not full, bit1 rx_full,
//                              bit2 tx_overflow.
//                         (W)  writing bit2 = 1 clears tx_overflow.
//   offset 0x04  rx data  (R)  {24'b0, rx_byte}; reading it with rx_full
//                              set consumes the byte.
//   offset 0x08  tx data  (W)  pushes io_wdata[7:0] into the TX FIFO.
//   offset 0x10  cycle_cnt (R) free-running cycle counter.
//   offset 0x14  instr_cnt (R) retired-instruction counter.
//   offset 0x18  counter clear (W) zeroes both counters.
//
// The page is selected when io_addr[31:28] == 4'h8; only io_addr[7:0]
// takes part in the register decode. Loads return data one cycle after
// the request edge (io_rdata is a register).
//
// Ports
//   clk, rst            single clock, synchronous active-low reset
//   io_addr/io_wdata    byte address and lane-aligned store data
//   io_wea              byte write enables (any bit set = store)
//   io_re               load request
//   instr_valid         one retired instruction this cycle
//   io_rdata            registered load data
//   uart_tx_*           byte stream towards the UART transmitter
//   uart_rx_*           byte stream from the UART receiver
//
// Handshakes: both UART streams use valid/ready. A byte transfers on a
// rising edge where valid and ready are both high. The sender holds valid
// and data stable until that edge; ready may change freely. Here the
// responder is the sender on uart_tx_* (valid = FIFO not empty, data =
// FIFO head) and the receiver on uart_rx_* (ready = holding register
// empty and not in reset).
// ---------------------------------------------------------------------------
module io_mem_responder #(
    parameter int TX_DEPTH = 4  // power of two, 2..16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wea,
    input  logic        io_re,
    input  logic        instr_valid,
    output logic [31:0] io_rdata,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_ready
);

    localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CNT_W = $clog2(TX_DEPTH + 1);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;

    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(TX_DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0]      cycle_cnt;
    logic [31:0]      instr_cnt;
    logic [7:0]       rx_byte;
    logic             rx_full;
    logic             tx_overflow;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tx_count;
    logic [7:0]       tx_mem [TX_DEPTH];

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic       sel;
    logic [7:0] off;
    logic       is_store;
    logic       is_load;

    assign sel      = (io_addr[31:28] == 4'h8);
    assign off      = io_addr[7:0];
    assign is_store = sel && (|io_wea);
    assign is_load  = sel && io_re;

    // Address bits 27:8 and store data above the low byte never reach any
    // register; the reduction keeps them visibly consumed.
    logic unused_bits;
    assign unused_bits = ^{io_addr[27:8], io_wdata[31:8]};

    // -----------------------------------------------------------------------
    // FIFO status and control
    // -----------------------------------------------------------------------
    logic tx_full;
    logic tx_empty;
    logic tx_push;
    logic tx_drop;
    logic tx_pop;

    assign tx_full  = (tx_count == COUNT_FULL);
    assign tx_empty = (tx_count == '0);

    // Fullness is judged at the start of the cycle: a pop in the same cycle
    // does not free a slot for a push into a full FIFO.
    assign tx_push = is_store && (off == OFF_TX) && !tx_full;
    assign tx_drop = is_store && (off == OFF_TX) && tx_full;
    assign tx_pop  = !tx_empty && uart_tx_ready;

    assign uart_tx_valid = !tx_empty;
    assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[rd_ptr];

    // -----------------------------------------------------------------------
    // RX holding register and other side effects
    // -----------------------------------------------------------------------
    logic rx_accept;
    logic rx_clear;
    logic ovf_clear;
    logic cnt_clear;

    assign uart_rx_ready = rst && !rx_full;
    assign rx_accept     = uart_rx_valid && uart_rx_ready;
    // rx_accept needs rx_full low and rx_clear needs it high, so the two
    // can never coincide.
    assign rx_clear      = is_load && (off == OFF_RX) && rx_full;
    assign ovf_clear     = is_store && (off == OFF_STATUS) && io_wdata[2];
    assign cnt_clear     = is_store && (off == OFF_CLEAR);

    // -----------------------------------------------------------------------
    // Read mux: values as they stand before this edge's updates. Offsets
    // that are write-only (0x08, 0x18) or unmapped read as zero.
    // -----------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'h0;
        case (off)
            OFF_STATUS: rd_mux = {29'h0, tx_overflow, rx_full, !tx_full};
            OFF_RX:     rd_mux = {24'h0, rx_byte};
            OFF_CYCLE:  rd_mux = cycle_cnt;
            OFF_INSTR:  rd_mux = instr_cnt;
            default:    rd_mux = 32'h0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            io_rdata    <= 32'h0;
            cycle_cnt   <= 32'h0;
            instr_cnt   <= 32'h0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_count    <= '0;
            rx_full     <= 1'b0;
            rx_byte     <= 8'h00;
            tx_overflow <= 1'b0;
        end else begin
            io_rdata <= is_load ? rd_mux : 32'h0;

            // A clear store wins over the increment of the same cycle.
            if (cnt_clear) begin
                cycle_cnt <= 32'h0;
                instr_cnt <= 32'h0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
                instr_cnt <= instr_cnt + 32'(instr_valid);
            end

            // Pointers are PTR_W bits wide and TX_DEPTH is a power of two,
            // so natural wrap gives the modulo behaviour.
            if (tx_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase

            // A dropped push and an overflow-clear store target different
            // offsets, so they cannot collide.
            if (tx_drop) begin
                tx_overflow <= 1'b1;
            end else if (ovf_clear) begin
                tx_overflow <= 1'b0;
            end

            if (rx_accept) begin
                rx_byte <= uart_rx_data;
                rx_full <= 1'b1;
            end else if (rx_clear) begin
                rx_full <= 1'b0;
            end
        end
    end

    // FIFO storage carries no reset; an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (rst && tx_push) begin
            tx_mem[wr_ptr] <= io_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_io_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_io_mem_responder
//
// Directed bench for io_mem_responder. Drivers issue loads, stores and UART
// traffic at posedge+1; expected load data and expected TX bytes go into
// queues at issue time, and a monitor on the falling edge pops and compares
// whenever the DUT produces a load response or a TX transfer.
// ---------------------------------------------------------------------------
module tb_io_mem_responder;

    // -----------------------------------------------------------------------
    // Clock / reset and DUT
    // -----------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wea;
    logic        io_re;
    logic        instr_valid;
    logic [31:0] io_rdata;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_ready;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_ready;

    always #5 clk = ~clk;

    io_mem_responder #(.TX_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_wea        (io_wea),
        .io_re         (io_re),
        .instr_valid   (instr_valid),
        .io_rdata      (io_rdata),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_ready (uart_rx_ready)
    );

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       exp_name_q[$];
    logic [7:0]  tx_exp_q[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Monitor: a load seen before an edge has its response checked on the
    // next falling edge; a TX transfer is judged on the valid/ready values
    // visible just before the edge that completes it.
    logic        rd_pending = 1'b0;
    logic [31:0] rd_exp;
    string       rd_name;
    logic [7:0]  tx_exp;

    always @(negedge clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%08h expected no response", io_rdata);
            end else begin
                rd_exp  = exp_q.pop_front();
                rd_name = exp_name_q.pop_front();
                check(rd_name, io_rdata, rd_exp);
            end
        end
        rd_pending = rst && io_re;

        if (rst && uart_tx_valid && uart_tx_ready) begin
            if (tx_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got 0x%02h expected no byte", uart_tx_data);
            end else begin
                tx_exp = tx_exp_q.pop_front();
                check("tx_byte", {24'h0, uart_tx_data}, {24'h0, tx_exp});
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        io_addr  = a;
        io_wdata = d;
        io_wea   = 4'hF;
        tick();
        io_wea   = 4'h0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] e,
                        input string nm);
        exp_q.push_back(e);
        exp_name_q.push_back(nm);
        io_addr = a;
        io_re   = 1'b1;
        tick();
        io_re   = 1'b0;
    endtask

    // Store one byte to the TX data register; 'emit' says whether that
    // byte is expected to come out of the FIFO later.
    task automatic tx_store(input logic [7:0] b, input bit emit);
        if (emit) tx_exp_q.push_back(b);
        store(32'h8000_0008, {24'h0, b});
    endtask

    task automatic rx_offer(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        tick();
        uart_rx_valid = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst           = 1'b0;
        io_addr       = 32'h0;
        io_wdata      = 32'h0;
        io_wea        = 4'h0;
        io_re         = 1'b0;
        instr_valid   = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;

        // Reset state
        idle(3);
        check("reset_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("reset_rx_ready", {31'h0, uart_rx_ready}, 32'h0);
        check("reset_rdata", io_rdata, 32'h0);
        rst = 1'b1;

        // Counters: first edge with rst high reads 0, the tenth-after reads 10
        idle(10);
        load(32'h8000_0010, 32'd10, "cycle_at_10");
        load(32'h8000_0014, 32'd0, "instr_idle");
        instr_valid = 1'b1;
        idle(3);
        instr_valid = 1'b0;
        load(32'h8000_0014, 32'd3, "instr_three");
        instr_valid = 1'b1;
        store(32'h8000_0018, 32'h0);          // clear beats this edge's increment
        instr_valid = 1'b0;
        load(32'h8000_0010, 32'd0, "cycle_after_clear");
        idle(2);
        load(32'h8000_0010, 32'd3, "cycle_clear_plus3");
        load(32'h8000_0014, 32'd0, "instr_after_clear");
        store(32'h8000_0010, 32'h0000_1234);  // read-only, ignored
        load(32'h8000_0010, 32'd6, "cycle_ro_store");
        store(32'h8000_0014, 32'h0000_0055);  // read-only, ignored
        load(32'h8000_0014, 32'd0, "instr_ro_store");

        // Unselected and unmapped reads
        load(32'h8000_0020, 32'h0, "unmapped_20");
        load(32'h0000_0010, 32'h0, "unselected_10");
        load(32'h9000_0010, 32'h0, "unselected_9");
        load(32'h8000_000C, 32'h0, "unmapped_0c");

        // TX overflow: five stores into a depth-4 FIFO with ready low
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) tx_store(8'h41 + 8'(i), i < 4);
        load(32'h8000_0000, 32'h4, "status_full_ovf");
        check("tx_valid_full", {31'h0, uart_tx_valid}, 32'h1);
        store(32'h8000_0000, 32'h3);          // bit2 clear: no effect
        load(32'h8000_0000, 32'h4, "status_ovf_kept");
        store(32'h8000_0000, 32'h4);
        load(32'h8000_0000, 32'h0, "status_ovf_cleared");
        uart_tx_ready = 1'b1;
        idle(8);
        check("tx_drain_a", exp_q.size() == 0 ? tx_exp_q.size() : 32'hFFFF, 32'h0);
        load(32'h8000_0000, 32'h1, "status_empty");
        uart_tx_ready = 1'b0;
        check("tx_valid_empty", {31'h0, uart_tx_valid}, 32'h0);

        // RX path
        rx_offer(8'h5A);
        check("rx_ready_full", {31'h0, uart_rx_ready}, 32'h0);
        load(32'h8000_0000, 32'h3, "status_rx_full");
        rx_offer(8'h77);                      // refused while full
        load(32'h8000_0004, 32'h5A, "rx_read");
        check("rx_ready_again", {31'h0, uart_rx_ready}, 32'h1);
        store(32'h8000_0004, 32'h0000_00EE);  // read-only, ignored
        load(32'h8000_0004, 32'h5A, "rx_held");
        load(32'h8000_0000, 32'h1, "status_rx_empty");
        rx_offer(8'hA5);
        load(32'h8000_0004, 32'hA5, "rx_second");

        // Simultaneous push/pop with two entries, 16 bytes across the wrap
        tx_store(8'h10, 1'b1);
        tx_store(8'h11, 1'b1);
        uart_tx_ready = 1'b1;
        for (int i = 2; i < 16; i++) tx_store(8'h10 + 8'(i), 1'b1);
        uart_tx_ready = 1'b0;
        tx_store(8'h20, 1'b1);
        tx_store(8'h21, 1'b1);
        load(32'h8000_0000, 32'h0, "status_full_stream");
        uart_tx_ready = 1'b1;
        tx_store(8'h99, 1'b0);                // full: pop happens, push dropped
        load(32'h8000_0000, 32'h5, "status_pop_no_credit");
        idle(6);
        check("tx_drain_b", tx_exp_q.size(), 32'h0);
        store(32'h8000_0000, 32'h4);
        load(32'h8000_0000, 32'h1, "status_clean");
        uart_tx_ready = 1'b0;

        // Reset in the middle of traffic
        tx_store(8'h61, 1'b0);
        tx_store(8'h62, 1'b0);
        tx_store(8'h63, 1'b0);
        rx_offer(8'hC3);
        check("pre_reset_tx_valid", {31'h0, uart_tx_valid}, 32'h1);
        check("pre_reset_rx_ready", {31'h0, uart_rx_ready}, 32'h0);
        rst           = 1'b0;
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'hD4;
        io_addr       = 32'h8000_0008;
        io_wdata      = 32'h0000_0064;
        io_wea        = 4'hF;
        tick();
        io_wea        = 4'h0;
        uart_rx_valid = 1'b0;
        check("midreset_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("midreset_rx_ready", {31'h0, uart_rx_ready}, 32'h0);
        check("midreset_rdata", io_rdata, 32'h0);
        rst = 1'b1;
        load(32'h8000_0000, 32'h1, "status_after_reset");
        load(32'h8000_0004, 32'h0, "rx_byte_after_reset");
        load(32'h8000_0010, 32'd2, "cycle_after_reset");
        check("rx_ready_after_reset", {31'h0, uart_rx_ready}, 32'h1);
        uart_tx_ready = 1'b0;

        idle(2);
        check("rd_queue_empty", exp_q.size(), 32'h0);
        check("tx_queue_empty", tx_exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
